// File: rtl/data_mem_mmio.sv
// Data memory for a single-cycle CPU: word RAM plus four MMIO registers
// (CYCLE, STATUS, LED, ID). Loads are combinational; stores commit on the rising edge.
module data_mem_mmio #(
  parameter int RAM_WORDS = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] adrDataMem,
  input  logic [31:0] WriteDataMem,
  output logic [31:0] DataMemOut,
  output logic [31:0] Leds,
  output logic        MemErr
);

  localparam int          AW     = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
  localparam logic [31:0] ID_VAL = 32'h4D49_5053;

  logic [31:0]   mem [2**AW];
  logic [31:0]   cycleReg, ledReg, mmioRd;
  logic [2:0]    statusReg, stSet, stClr;
  logic [AW-1:0] ramIdx;
  logic          aligned, access, inRam, isMmio, legal, wrLegal;
  logic          wrCycle, wrStatus, wrLed;

  always_comb begin
    aligned  = (adrDataMem[1:0] == 2'b00);
    access   = MemRead | MemWrite;
    inRam    = (adrDataMem[31:2] < 30'(RAM_WORDS));
    isMmio   = (adrDataMem[31:4] == 28'h000_0100);
    legal    = aligned & (inRam | isMmio);
    wrLegal  = MemWrite & legal;
    ramIdx   = adrDataMem[AW+1:2];
    wrCycle  = wrLegal & isMmio & (adrDataMem[3:2] == 2'd0);
    wrStatus = wrLegal & isMmio & (adrDataMem[3:2] == 2'd1);
    wrLed    = wrLegal & isMmio & (adrDataMem[3:2] == 2'd2);
  end

  // Error flags: [0] misaligned, [1] out-of-range, [2] read+write collision.
  always_comb begin
    stSet[0] = access & ~aligned;
    stSet[1] = access & aligned & ~inRam & ~isMmio;
    stSet[2] = MemRead & MemWrite;
    stClr    = wrStatus ? WriteDataMem[2:0] : 3'b000;
  end

  always_comb begin
    unique case (adrDataMem[3:2])
      2'd0:    mmioRd = cycleReg;
      2'd1:    mmioRd = {29'd0, statusReg};
      2'd2:    mmioRd = ledReg;
      default: mmioRd = ID_VAL;
    endcase
  end

  // State is read before the edge, so a same-cycle store returns the old value.
  always_comb begin
    DataMemOut = '0;
    if (MemRead && legal)
      DataMemOut = inRam ? mem[ramIdx] : mmioRd;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cycleReg  <= '0;
      statusReg <= '0;
      ledReg    <= '0;
    end else begin
      cycleReg  <= wrCycle ? WriteDataMem : cycleReg + 32'd1;
      statusReg <= (statusReg & ~stClr) | stSet;
      if (wrLed) ledReg <= WriteDataMem;
    end
  end

  // RAM has no reset; a store landing while reset is held is dropped.
  always_ff @(posedge clk) begin
    if (rst && wrLegal && inRam) mem[ramIdx] <= WriteDataMem;
  end

  assign Leds   = ledReg;
  assign MemErr = |statusReg;

endmodule

// File: doc/data_mem_mmio.md
DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, asynchronous, active-low.
REQ-003 SHALL have port MemRead, input, 1 bit: read strobe from the CPU.
REQ-004 SHALL have port MemWrite, input, 1 bit: write strobe from the CPU.
REQ-005 SHALL have port adrDataMem, input, 32 bits: byte address.
REQ-006 SHALL have port WriteDataMem, input, 32 bits: store data.
REQ-007 SHALL have port DataMemOut, output, 32 bits: load data, combinational.
REQ-008 SHALL have port Leds, output, 32 bits: current value of the LED register.
REQ-009 SHALL have port MemErr, output, 1 bit: OR of the STATUS bits.
REQ-010 SHALL have parameter RAM_WORDS, default 1024: RAM depth in 32-bit words; the value SHALL be a power of 2 and no greater than 1024.

Function
REQ-011 SHALL decode RAM at byte addresses 0x0000_0000 to 4*RAM_WORDS-1, word index adr[11:2].
REQ-012 SHALL decode four MMIO registers: 0x0000_1000 CYCLE (R/W), 0x0000_1004 STATUS (read, write-1-to-clear), 0x0000_1008 LED (R/W), 0x0000_100C ID (read-only, 0x4D495053).
REQ-013 SHALL treat any other address as out-of-range.
REQ-014 SHALL produce DataMemOut combinationally in the same cycle; latency 0, as required by a single-cycle CPU.
REQ-015 SHALL drive DataMemOut to the decoded word when MemRead=1 and the access is aligned and in range; otherwise it SHALL drive 0.
REQ-016 SHALL perform writes at the rising clk edge when MemWrite=1; a read of the same address in the same cycle SHALL return the old value (read-before-write).
REQ-017 SHALL treat an access as misaligned when (MemRead|MemWrite)=1 and adr[1:0]!=0.
REQ-018 SHALL, for a misaligned access: suppress the write, read 0, and set STATUS[0].
REQ-019 SHALL, for an out-of-range aligned access: suppress the write, read 0, and set STATUS[1].
REQ-020 SHALL, when MemRead=1 and MemWrite=1 together: set STATUS[2]; the write still proceeds if legal.
REQ-021 SHALL keep STATUS[31:3] reading 0.
REQ-022 SHALL clear each STATUS bit i when a legal write to STATUS has WriteDataMem[i]=1.
REQ-023 SHALL give set priority over clear when a set and a clear of the same bit occur in the same cycle.
REQ-024 SHALL increment CYCLE by 1 every clk edge and wrap 0xFFFF_FFFF -> 0x0000_0000.
REQ-025 SHALL, on a legal write to CYCLE, load WriteDataMem instead of incrementing; the loaded value SHALL be visible the next cycle and increment thereafter.
REQ-026 SHALL make writes to ID and out-of-range addresses have no effect on any state other than STATUS.
REQ-027 SHALL drive Leds directly from the LED register.
REQ-028 SHALL drive MemErr as |STATUS[2:0].
REQ-029 SHALL ignore adrDataMem and WriteDataMem when MemRead=0 and MemWrite=0, with no STATUS change.

Reset
REQ-030 SHALL, while rst=0, immediately force CYCLE=0, STATUS=0, LED=0; Leds=0, MemErr=0.
REQ-031 SHALL hold CYCLE at 0 while rst=0, with the first increment on the first clk edge after rst rises.
REQ-032 SHALL NOT reset RAM contents; they are undefined until written.
REQ-033 SHALL discard any write pending in the cycle in which rst is asserted asynchronously.

Verification
REQ-034 SHALL be covered by scenario: write 0xDEADBEEF to 0x0000_0010, then read 0x10 -> DataMemOut=0xDEADBEEF; read with MemRead=0 -> 0.
REQ-035 SHALL be covered by scenario: write 0x00000005 to 0x1008 -> Leds=0x00000005 the next cycle; read 0x100C -> 0x4D495053; write to 0x100C -> ID unchanged.
REQ-036 SHALL be covered by scenario: write to 0x0000_0012 -> RAM unchanged, STATUS=0x1, MemErr=1; write 0x1 to 0x1004 -> STATUS=0, MemErr=0.
REQ-037 SHALL be covered by scenario: read 0x0000_2000 -> DataMemOut=0, STATUS[1]=1; the same-cycle set and clear of STATUS[1] -> bit stays 1.
REQ-038 SHALL be covered by scenario: write 0xFFFFFFFE to 0x1000 -> CYCLE reads 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 on three consecutive cycles.
REQ-039 SHALL be covered by scenario: assert rst mid-write with LED=0x5 and STATUS=0x4 -> Leds=0 and MemErr=0 immediately, and CYCLE=0 after release.
